// File: rtl/vga_controller.sv
// VGA raster timing generator: 12-bit x/y counters plus one registered output stage.
// Optional VGA_FRAME_TICK_EN builds a one-clock frame_tick at the start of vertical blanking.
module vga_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        video_on,
  output logic        hsync,
  output logic        vsync,
  output logic        vga_r,
  output logic        vga_g,
  output logic        vga_b,
  output logic        frame_tick
);

  localparam logic [11:0] H_TOTAL  = 12'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [11:0] V_TOTAL  = 12'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
  localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC);

  function automatic logic in_window(input logic [11:0] v, input logic [11:0] lo,
                                     input logic [11:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

  logic [11:0] x_p0;
  logic [11:0] y_p0;
  logic        x_wrap;
  logic        vis_p0;

  // Stage p0: raster counters; >= comparisons also recover from out-of-range values
  assign x_wrap = (x_p0 >= H_TOTAL - 12'd1);
  assign vis_p0 = (x_p0 < H_VIS) && (y_p0 < V_VIS);

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else begin
      x_p0 <= x_wrap ? 12'd0 : x_p0 + 12'd1;
      if (y_p0 >= V_TOTAL)
        y_p0 <= '0;
      else if (x_wrap)
        y_p0 <= (y_p0 >= V_TOTAL - 12'd1) ? 12'd0 : y_p0 + 12'd1;
    end
  end

  assign x        = x_p0;
  assign y        = y_p0;
  assign video_on = vis_p0;

  // Stage p1: pin registers, all sampled from the same (x,y)
  logic       hsync_p1;
  logic       vsync_p1;
  logic [2:0] rgb_p1;

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      hsync_p1 <= 1'b1;
      vsync_p1 <= 1'b1;
      rgb_p1   <= '0;
    end else begin
      hsync_p1 <= ~in_window(x_p0, HS_START, HS_END);
      vsync_p1 <= ~in_window(y_p0, VS_START, VS_END);
      rgb_p1   <= color & {3{vis_p0}};
    end
  end

  assign hsync = hsync_p1;
  assign vsync = vsync_p1;
  assign vga_r = rgb_p1[2];
  assign vga_g = rgb_p1[1];
  assign vga_b = rgb_p1[0];

`ifdef VGA_FRAME_TICK_EN
  logic tick_p1;

  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N)
      tick_p1 <= 1'b0;
    else
      tick_p1 <= (x_p0 == 12'd0) && (y_p0 == V_VIS);
  end

  assign frame_tick = tick_p1;
`else
  assign frame_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_controller.sv
// Scoreboard bench for vga_controller using a reduced raster so several frames run quickly.
module tb_vga_controller;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        CLOCK_25 = 1'b0;
  logic        RESET_N;
  logic [2:0]  color;
  logic [11:0] x, y;
  logic        video_on, hsync, vsync, vga_r, vga_g, vga_b, frame_tick;

  vga_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .color(color),
    .x(x), .y(y), .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_tick(frame_tick)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [30:0] sb[$];
  int k = 0;
  int ecount = 0, tcount = 0;
  int hs_cnt = 0, vs_cnt = 0, hs_run = 0, vs_run = 0, first_fall = -1;
  int tick_cnt = 0, last_tick = -1;
  logic prev_hs = 1'b1, prev_vs = 1'b1;

  // One clock: drive inputs, predict the post-edge outputs, then compare at the falling edge.
  task automatic step(input logic rn, input logic [2:0] col);
    int cx, cy, nx, ny;
    logic ehs, evs, etk, evo;
    logic [2:0] ergb;
    logic [30:0] exp_v, got_v;
    RESET_N = rn;
    color   = col;
    cx = k % HT;
    cy = k / HT;
    if (rn) begin
      ehs  = !(cx >= HV + HF && cx < HV + HF + HS);
      evs  = !(cy >= VV + VF && cy < VV + VF + VS);
      ergb = (cx < HV && cy < VV) ? col : 3'b000;
`ifdef VGA_FRAME_TICK_EN
      etk  = (cx == 0 && cy == VV);
`else
      etk  = 1'b0;
`endif
      k = (k + 1) % FRAME;
    end else begin
      ehs = 1'b1; evs = 1'b1; ergb = 3'b000; etk = 1'b0;
      k = 0;
    end
    nx  = k % HT;
    ny  = k / HT;
    evo = (nx < HV) && (ny < VV);
    sb.push_back({12'(nx), 12'(ny), evo, ehs, evs, ergb, etk});

    @(negedge CLOCK_25);
    tcount++;
    exp_v = sb.pop_front();
    got_v = {x, y, video_on, hsync, vsync, vga_r, vga_g, vga_b, frame_tick};
    check("pins", 64'(got_v), 64'(exp_v));

    if (!rn) begin
      ecount = 0; last_tick = -1;
    end else begin
      ecount++;
    end
    if (prev_hs && !hsync) begin
      hs_cnt++;
      if (first_fall < 0) first_fall = ecount;
    end
    if (!prev_hs && hsync) check("hs_width", 64'(hs_run), 64'(HS));
    hs_run = hsync ? 0 : hs_run + 1;
    if (prev_vs && !vsync) vs_cnt++;
    if (!prev_vs && vsync) check("vs_width", 64'(vs_run), 64'(VS * HT));
    vs_run = vsync ? 0 : vs_run + 1;
    prev_hs = hsync;
    prev_vs = vsync;
    if (frame_tick) begin
      tick_cnt++;
      if (last_tick >= 0) check("tick_gap", 64'(tcount - last_tick), 64'(FRAME));
      last_tick = tcount;
    end
  endtask

  task automatic frame_stats_check(input string tag);
    hs_cnt = 0; vs_cnt = 0; first_fall = -1;
    repeat (FRAME) step(1'b1, 3'b101);
    check({tag, "_hs_count"}, 64'(hs_cnt), 64'(VT));
    check({tag, "_vs_count"}, 64'(vs_cnt), 64'(1));
    check({tag, "_first_hs_fall"}, 64'(first_fall), 64'(HV + HF + 1));
  endtask

  initial begin
    RESET_N = 1'b0;
    color   = 3'b000;
    repeat (3) step(1'b0, 3'($urandom_range(0, 7)));

    frame_stats_check("post_reset");

    repeat (FRAME) step(1'b1, 3'($urandom_range(0, 7)));

    for (int i = 0; i < FRAME && k != 5 * HT + 12; i++)
      step(1'b1, 3'($urandom_range(0, 7)));
    check("mid_reset_pos", 64'(k), 64'(5 * HT + 12));
    step(1'b0, 3'b111);
    frame_stats_check("after_mid_reset");

    tick_cnt = 0;
    repeat (3 * FRAME) step(1'b1, 3'($urandom_range(0, 7)));
`ifdef VGA_FRAME_TICK_EN
    check("tick_count", 64'(tick_cnt), 64'(3));
`else
    check("tick_count", 64'(tick_cnt), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in clocks.
REQ-004 Parameter H_BACK, 48, horizontal back porch in clocks.
REQ-005 Parameter V_VISIBLE, 480, visible lines per frame.
REQ-006 Parameter V_FRONT, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BACK, 33, vertical back porch in lines.
REQ-009 CLOCK_25  input  1  pixel clock; one clock, all logic on its rising edge.
REQ-010 RESET_N  input  1  synchronous, active-low reset.
REQ-011 color  input  3  pixel colour {R,G,B} from the image generator for the current x,y.
REQ-012 x  output  12  current horizontal count.
REQ-013 y  output  12  current vertical count.
REQ-014 video_on  output  1  high when x < H_VISIBLE and y < V_VISIBLE.
REQ-015 hsync  output  1  horizontal sync, active low, pipeline-aligned with rgb.
REQ-016 vsync  output  1  vertical sync, active low, pipeline-aligned with rgb.
REQ-017 vga_r, vga_g, vga_b  output  1 each  registered colour to the DAC pins.
REQ-018 frame_tick  output  1  one-cycle pulse per frame (see Configuration).

Function
REQ-019 H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
REQ-020 x increments by 1 every clock, from 0 to H_TOTAL-1, then wraps to 0.
REQ-021 y increments by 1 only on the clock where x wraps; at x = H_TOTAL-1 and y = V_TOTAL-1 both wrap to 0 on the same edge.
REQ-022 x and y are registered and change only on clock edges; the image generator's colour for (x,y) is valid combinationally in that same cycle.
REQ-023 The horizontal sync condition is H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC (656..751).
REQ-024 The vertical sync condition is V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC (490..491).
REQ-025 Output stage: one register stage; vga_r/g/b = color[2]/[1]/[0] AND video_on; hsync/vsync = inverted sync condition. All are sampled from the same (x,y), giving 1-clock latency from x,y to pins.
REQ-026 video_on is combinational from x,y (unregistered), for use by the image generator.
REQ-027 Counter arithmetic is 12-bit unsigned; counts never exceed H_TOTAL-1 or V_TOTAL-1.
REQ-028 Out-of-range values (e.g. forced by an X-to-known transition) are caught by a >= comparison, not ==, and wrap to 0 on the next clock.

Reset
REQ-029 While RESET_N is low at a clock edge: x=0, y=0, hsync=1, vsync=1, vga_r/g/b=0, frame_tick=0.
REQ-030 Reset asserted mid-frame takes effect on the next edge and discards the frame in progress; counting restarts at (0,0) on the first edge with RESET_N high.
REQ-031 The first registered pixel after reset release appears on the pins one clock after the counters leave reset.

Configuration
REQ-032 Macro VGA_FRAME_TICK_EN: when defined, frame_tick pulses high for exactly one clock, registered, on the cycle the output stage presents x=0,y=V_VISIBLE (start of vertical blanking), once per frame; game logic uses it as a frame-rate update clock enable.
REQ-033 Without VGA_FRAME_TICK_EN, frame_tick is tied to 0 and no related logic is built; all other behaviour is identical.

Verification
REQ-034 Release reset and run 800 clocks -> x steps 0..799 then 0, and y goes from 0 to 1 on the same edge that x wraps.
REQ-035 Run one full frame (420000 clocks) -> exactly 525 hsync pulses of 96 clocks each and one vsync pulse of 1600 clocks; first hsync falls one clock after x=656.
REQ-036 Drive color=3'b101 constantly -> vga_r=1,g=0,b=1 only for registered pixels with x<640,y<480; all zero during blanking, including at x=640 and y=480.
REQ-037 Assert RESET_N low at x=300,y=200 for 1 clock -> next edge x=0,y=0, outputs at reset values; the next frame timing is identical to the post-reset run.
REQ-038 With VGA_FRAME_TICK_EN defined, run 3 frames -> frame_tick pulses 3 times, 420000 clocks apart, each one clock wide; without the macro, frame_tick stays 0.
